// File: rtl/reg_file_x_if.sv
// Control/data bus of the register file: the master drives the decode and
// writeback controls, the slave returns register views and shadow-stack status.
interface reg_file_x_if #(
  parameter int DATA_W   = 16,
  parameter int SH_DEPTH = 2
);
  localparam int DEP_W = $clog2(SH_DEPTH + 1);

  logic              IdxF, IF, SPF, INTACK, RETI, Ex;
  logic [3:0]        SRnew, srcA, dstA;
  logic [1:0]        Size;
  logic              srcInc, dstInc, RW;
  logic [DATA_W-1:0] result, ISR;
  logic [DATA_W-1:0] PCout, SPout, Rsrc, Rdst;
  logic [3:0]        SRcurrent;
  logic              GIE;
  logic [DEP_W-1:0]  ShDepth;
  logic              ShErr;

  modport master (
    output IdxF, IF, SPF, INTACK, RETI, Ex, SRnew, srcA, dstA, Size,
           srcInc, dstInc, RW, result, ISR,
    input  PCout, SPout, Rsrc, Rdst, SRcurrent, GIE, ShDepth, ShErr
  );

  modport slave (
    input  IdxF, IF, SPF, INTACK, RETI, Ex, SRnew, srcA, dstA, Size,
           srcInc, dstInc, RW, result, ISR,
    output PCout, SPout, Rsrc, Rdst, SRcurrent, GIE, ShDepth, ShErr
  );
endinterface

// File: rtl/reg_file_x.sv
// 16-entry register file: R0=PC, R1=SP, R2=SR, R3=constant zero.
// Per-register next-state logic resolves same-cycle requests by fixed priority;
// a small LIFO shadow stack saves {PC, SR} across interrupt entry/return.
module reg_file_x #(
  parameter int DATA_W   = 16,
  parameter int NREG     = 16,
  parameter int SH_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_x_if.slave  bus
);
  localparam int DEP_W = $clog2(SH_DEPTH + 1);
  localparam logic [DATA_W-1:0] ADDR_STEP = (DATA_W > 16) ? DATA_W'(4) : DATA_W'(2);

  logic [NREG-1:0][DATA_W-1:0]     w_regs;
  logic [DATA_W-1:0]               w_rwData, w_stepG, w_stepP, w_topPc, w_topSr;
  logic                            w_full, w_empty, w_push, w_pop, w_err;
  logic [SH_DEPTH-1:0][DATA_W-1:0] r_shPc, r_shSr;
  logic [DEP_W-1:0]                r_depth;
  logic                            r_err;

  // Writeback data sized by the access width (zero-extended)
  always_comb begin
    w_rwData = '0;
    case (bus.Size)
      2'b01:   w_rwData[7:0]  = bus.result[7:0];
      2'b10:   w_rwData       = bus.result;
      default: w_rwData[15:0] = bus.result[15:0];
    endcase
  end

  // Autoincrement steps: general registers, and PC/SP which stay word aligned
  always_comb begin
    w_stepG = DATA_W'(2);
    w_stepP = DATA_W'(2);
    case (bus.Size)
      2'b01:   w_stepG = DATA_W'(1);
      2'b10: begin
        w_stepG = ADDR_STEP;
        w_stepP = ADDR_STEP;
      end
      default: ;
    endcase
  end

  // INTACK always wins over RETI; a blocked push or an empty pop flags an error
  assign w_full  = (r_depth == DEP_W'(SH_DEPTH));
  assign w_empty = (r_depth == '0);
  assign w_push  = bus.INTACK && !w_full;
  assign w_pop   = bus.RETI && !bus.INTACK && !w_empty;
  assign w_err   = (bus.INTACK && w_full) || (bus.RETI && !bus.INTACK && w_empty);

  // Top-of-stack view used by RETI
  always_comb begin
    w_topPc = '0;
    w_topSr = '0;
    for (int k = 0; k < SH_DEPTH; k++)
      if (r_depth == DEP_W'(k + 1)) begin
        w_topPc = r_shPc[k];
        w_topSr = r_shSr[k];
      end
  end

  // Shadow stack contents, occupancy and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shPc  <= '0;
      r_shSr  <= '0;
      r_depth <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_err) r_err <= 1'b1;
      if (w_push) begin
        for (int k = 0; k < SH_DEPTH; k++)
          if (r_depth == DEP_W'(k)) begin
            r_shPc[k] <= w_regs[0];
            r_shSr[k] <= w_regs[2];
          end
        r_depth <= r_depth + DEP_W'(1);
      end else if (w_pop) begin
        r_depth <= r_depth - DEP_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    if (g == 3) begin : g_cg2
      assign w_regs[g] = '0;
    end else begin : g_live
      localparam bit IS_PTR = (g < 2);
      localparam bit IS_SR  = (g == 2);
      logic [DATA_W-1:0] r_q, w_nxt, w_rw, w_step;
      logic              w_dSel, w_sSel;

      assign w_dSel = (bus.dstA == 4'(g));
      assign w_sSel = (bus.srcA == 4'(g));
      assign w_step = IS_PTR ? w_stepP : w_stepG;

      // Writeback value shaped for this register (PC/SP even, SR 9 bits)
      always_comb begin
        w_rw = w_rwData;
        if (IS_PTR) w_rw[0] = 1'b0;
        if (IS_SR)  w_rw = {{(DATA_W-9){1'b0}}, w_rwData[8:0]};
      end

      // Next value: dstInc > srcInc > RW > INTACK/RETI > IF/IdxF > SPF > Ex
      always_comb begin
        w_nxt = r_q;
        if (!IS_SR && bus.dstInc && w_dSel)      w_nxt = r_q + w_step;
        else if (!IS_SR && bus.srcInc && w_sSel) w_nxt = r_q + w_step;
        else if (bus.RW && w_dSel)               w_nxt = w_rw;
        else if (g == 0 && bus.INTACK)           w_nxt = {bus.ISR[DATA_W-1:1], 1'b0};
        else if (g == 0 && w_pop)                w_nxt = w_topPc;
        else if (g == 2 && bus.INTACK)           w_nxt = '0;
        else if (g == 2 && w_pop)                w_nxt = w_topSr;
        else if (g == 0 && (bus.IF || bus.IdxF)) w_nxt = r_q + DATA_W'(2);
        else if (g == 1 && bus.SPF)              w_nxt = r_q - DATA_W'(2);
        else if (g == 2 && bus.Ex) begin
          w_nxt[8]   = bus.SRnew[3];
          w_nxt[2:0] = bus.SRnew[2:0];
        end
      end

      // Register storage
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_q <= '0;
        else     r_q <= w_nxt;
      end

      assign w_regs[g] = r_q;
    end
  end

  assign bus.PCout     = w_regs[0];
  assign bus.SPout     = w_regs[1];
  assign bus.Rsrc      = w_regs[bus.srcA];
  assign bus.Rdst      = w_regs[bus.dstA];
  assign bus.SRcurrent = {w_regs[2][8], w_regs[2][2:0]};
  assign bus.GIE       = w_regs[2][3];
  assign bus.ShDepth   = r_depth;
  assign bus.ShErr     = r_err;
endmodule

// File: tb/tb_reg_file_x.sv
// Bench for reg_file_x (DATA_W=20, SH_DEPTH=2): directed scenarios with
// spec-derived constants plus a randomized run against a behavioural model.
module tb_reg_file_x;
  localparam int DW = 20;
  localparam int SD = 2;

  logic clk, rst;
  int   tests = 0;
  int   fails = 0;

  reg_file_x_if #(.DATA_W(DW), .SH_DEPTH(SD)) bus ();
  reg_file_x #(.DATA_W(DW), .NREG(16), .SH_DEPTH(SD)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #20 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Reference model: register array, context queue (back = top), sticky error
  typedef struct { logic [DW-1:0] pc; logic [DW-1:0] sr; } ctx_t;
  logic [DW-1:0] m_r [16];
  ctx_t          m_q [$];
  logic          m_err;

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    m_q.delete();
    m_err = 1'b0;
  endtask

  function automatic logic [DW-1:0] inc_of(int r, logic [1:0] sz);
    if (sz == 2'b01) return (r < 2) ? DW'(2) : DW'(1);
    if (sz == 2'b10) return DW'(4);
    return DW'(2);
  endfunction

  // Apply lowest-priority effects first, letting higher-priority ones overwrite
  task automatic m_step();
    logic [DW-1:0] nr [16];
    logic [DW-1:0] v;
    ctx_t c;
    nr = m_r;
    if (bus.Ex) begin
      nr[2][8]   = bus.SRnew[3];
      nr[2][2:0] = bus.SRnew[2:0];
    end
    if (bus.SPF) nr[1] = m_r[1] - DW'(2);
    if (bus.IF || bus.IdxF) nr[0] = m_r[0] + DW'(2);
    if (bus.INTACK) begin
      if (m_q.size() < SD) begin
        c.pc = m_r[0];
        c.sr = m_r[2];
        m_q.push_back(c);
      end else m_err = 1'b1;
      nr[0] = {bus.ISR[DW-1:1], 1'b0};
      nr[2] = '0;
    end else if (bus.RETI) begin
      if (m_q.size() > 0) begin
        c = m_q.pop_back();
        nr[0] = c.pc;
        nr[2] = c.sr;
      end else m_err = 1'b1;
    end
    if (bus.RW) begin
      case (bus.Size)
        2'b01:   v = DW'(bus.result[7:0]);
        2'b10:   v = bus.result;
        default: v = DW'(bus.result[15:0]);
      endcase
      if (bus.dstA < 4'd2)  v[0] = 1'b0;
      if (bus.dstA == 4'd2) v = v & DW'(20'h001FF);
      nr[bus.dstA] = v;
    end
    if (bus.srcInc && bus.srcA != 4'd2)
      nr[bus.srcA] = m_r[bus.srcA] + inc_of(int'(bus.srcA), bus.Size);
    if (bus.dstInc && bus.dstA != 4'd2)
      nr[bus.dstA] = m_r[bus.dstA] + inc_of(int'(bus.dstA), bus.Size);
    nr[3] = '0;
    m_r = nr;
  endtask

  task automatic idle();
    bus.IdxF = 0; bus.IF = 0; bus.SPF = 0; bus.INTACK = 0; bus.RETI = 0; bus.Ex = 0;
    bus.SRnew = '0; bus.srcA = '0; bus.dstA = '0; bus.Size = '0;
    bus.srcInc = 0; bus.dstInc = 0; bus.RW = 0; bus.result = '0; bus.ISR = '0;
  endtask

  task automatic cyc();
    m_step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input logic [3:0] a, input logic [DW-1:0] v);
    idle();
    bus.RW = 1; bus.dstA = a; bus.Size = 2'b10; bus.result = v;
    cyc();
  endtask

  task automatic rd(input logic [3:0] a, output logic [DW-1:0] v);
    bus.srcA = a;
    #1;
    v = bus.Rsrc;
  endtask

  task automatic test_reset();
    logic [DW-1:0] v;
    idle();
    bus.RW = 1; bus.dstA = 4'd4; bus.Size = 2'b10; bus.result = 20'h12345;
    bus.IF = 1; bus.INTACK = 1; bus.ISR = 20'h00100;
    @(posedge clk); @(posedge clk); #1;
    idle();
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), v);
      tests++;
      if (v !== '0) begin fails++; $display("FAIL reset_R%0d got=%h exp=0", i, v); end
    end
    tests++;
    if (bus.PCout !== '0 || bus.SPout !== '0 || bus.SRcurrent !== '0 || bus.GIE !== 1'b0 ||
        bus.ShDepth !== '0 || bus.ShErr !== 1'b0) begin
      fails++;
      $display("FAIL reset_status pc=%h sp=%h sr=%h gie=%b dep=%0d err=%b exp=all0",
               bus.PCout, bus.SPout, bus.SRcurrent, bus.GIE, bus.ShDepth, bus.ShErr);
    end
  endtask

  task automatic test_rw();
    logic [DW-1:0] v;
    idle(); bus.RW = 1; bus.dstA = 4'd4; bus.Size = 2'b01; bus.result = 20'h0ABCD; cyc();
    rd(4'd4, v); tests++;
    if (v !== 20'h000CD) begin fails++; $display("FAIL rw_byte got=%h exp=000cd", v); end
    idle(); bus.RW = 1; bus.dstA = 4'd4; bus.Size = 2'b00; bus.result = 20'h0ABCD; cyc();
    rd(4'd4, v); tests++;
    if (v !== 20'h0ABCD) begin fails++; $display("FAIL rw_word got=%h exp=0abcd", v); end
    idle(); bus.RW = 1; bus.dstA = 4'd9; bus.Size = 2'b11; bus.result = 20'hF1234; cyc();
    rd(4'd9, v); tests++;
    if (v !== 20'h01234) begin fails++; $display("FAIL rw_size11 got=%h exp=01234", v); end
    idle(); bus.RW = 1; bus.dstA = 4'd0; bus.Size = 2'b00; bus.result = 20'h01235; cyc();
    tests++;
    if (bus.PCout !== 20'h01234) begin fails++; $display("FAIL rw_pc_align got=%h exp=01234", bus.PCout); end
    wr(4'd2, 20'hFFFFF);
    rd(4'd2, v); tests++;
    if (v !== 20'h001FF || bus.SRcurrent !== 4'hF || bus.GIE !== 1'b1) begin
      fails++; $display("FAIL rw_sr got=%h/%h/%b exp=001ff/f/1", v, bus.SRcurrent, bus.GIE);
    end
    wr(4'd3, 20'h12345);
    rd(4'd3, v); tests++;
    if (v !== '0) begin fails++; $display("FAIL rw_r3 got=%h exp=0", v); end
  endtask

  task automatic test_autoinc();
    logic [DW-1:0] v;
    wr(4'd5, 20'hFFFFE);
    idle(); bus.srcInc = 1; bus.srcA = 4'd5; bus.Size = 2'b10; cyc();
    rd(4'd5, v); tests++;
    if (v !== 20'h00002) begin fails++; $display("FAIL inc_addr_wrap got=%h exp=00002", v); end
    wr(4'd1, 20'h00100);
    idle(); bus.srcInc = 1; bus.srcA = 4'd1; bus.Size = 2'b01; cyc();
    tests++;
    if (bus.SPout !== 20'h00102) begin fails++; $display("FAIL inc_sp_byte got=%h exp=00102", bus.SPout); end
    idle(); bus.dstInc = 1; bus.dstA = 4'd7; bus.Size = 2'b01; cyc();
    rd(4'd7, v); tests++;
    if (v !== 20'h00001) begin fails++; $display("FAIL inc_byte got=%h exp=00001", v); end
    idle(); bus.srcInc = 1; bus.srcA = 4'd2; bus.dstInc = 1; bus.dstA = 4'd3; cyc();
    rd(4'd2, v); tests++;
    if (v !== 20'h001FF) begin fails++; $display("FAIL inc_sr_blocked got=%h exp=001ff", v); end
    rd(4'd3, v); tests++;
    if (v !== '0) begin fails++; $display("FAIL inc_r3_blocked got=%h exp=0", v); end
    idle(); bus.dstInc = 1; bus.dstA = 4'd0; bus.Size = 2'b10; cyc();
    tests++;
    if (bus.PCout !== 20'h01238) begin fails++; $display("FAIL inc_pc_addr got=%h exp=01238", bus.PCout); end
  endtask

  task automatic test_priority();
    logic [DW-1:0] v;
    wr(4'd6, 20'h00020);
    idle(); bus.RW = 1; bus.dstInc = 1; bus.dstA = 4'd6; bus.Size = 2'b00; bus.result = 20'h00010; cyc();
    rd(4'd6, v); tests++;
    if (v !== 20'h00022) begin fails++; $display("FAIL prio_dstinc_rw got=%h exp=00022", v); end
    idle(); bus.IF = 1; bus.RW = 1; bus.dstA = 4'd0; bus.Size = 2'b00; bus.result = 20'h00500; cyc();
    tests++;
    if (bus.PCout !== 20'h00500) begin fails++; $display("FAIL prio_rw_if got=%h exp=00500", bus.PCout); end
    idle(); bus.IdxF = 1; bus.SPF = 1; cyc();
    tests++;
    if (bus.PCout !== 20'h00502 || bus.SPout !== 20'h00100) begin
      fails++; $display("FAIL fetch_push got=%h/%h exp=00502/00100", bus.PCout, bus.SPout);
    end
    idle(); bus.Ex = 1; bus.SRnew = 4'b0000; cyc();
    rd(4'd2, v); tests++;
    if (v !== 20'h000F8 || bus.SRcurrent !== 4'h0 || bus.GIE !== 1'b1) begin
      fails++; $display("FAIL ex_flags got=%h/%h/%b exp=000f8/0/1", v, bus.SRcurrent, bus.GIE);
    end
  endtask

  task automatic test_interrupt();
    logic [DW-1:0] v;
    wr(4'd0, 20'h04000);
    wr(4'd2, 20'h00008);
    idle(); bus.INTACK = 1; bus.ISR = 20'h0F001; cyc();
    rd(4'd2, v); tests++;
    if (bus.PCout !== 20'h0F000 || v !== '0 || bus.ShDepth !== 2'd1) begin
      fails++; $display("FAIL int_entry got=%h/%h/%0d exp=0f000/0/1", bus.PCout, v, bus.ShDepth);
    end
    idle(); bus.RETI = 1; cyc();
    rd(4'd2, v); tests++;
    if (bus.PCout !== 20'h04000 || v !== 20'h00008 || bus.ShDepth !== 2'd0 || bus.ShErr !== 1'b0) begin
      fails++; $display("FAIL int_return got=%h/%h/%0d/%b exp=04000/00008/0/0", bus.PCout, v, bus.ShDepth, bus.ShErr);
    end
    idle(); bus.INTACK = 1; bus.RETI = 1; bus.ISR = 20'h00A00; cyc();
    tests++;
    if (bus.PCout !== 20'h00A00 || bus.ShDepth !== 2'd1 || bus.ShErr !== 1'b0) begin
      fails++; $display("FAIL int_vs_reti got=%h/%0d/%b exp=00a00/1/0", bus.PCout, bus.ShDepth, bus.ShErr);
    end
    idle(); bus.RETI = 1; cyc();
    tests++;
    if (bus.PCout !== 20'h04000 || bus.ShDepth !== 2'd0) begin
      fails++; $display("FAIL int_vs_reti_ret got=%h/%0d exp=04000/0", bus.PCout, bus.ShDepth);
    end
  endtask

  task automatic test_nesting();
    logic [DW-1:0] v;
    idle(); bus.INTACK = 1; bus.ISR = 20'h00200; cyc();
    wr(4'd2, 20'h00104);
    idle(); bus.INTACK = 1; bus.ISR = 20'h00300; cyc();
    idle(); bus.INTACK = 1; bus.ISR = 20'h00400; cyc();
    tests++;
    if (bus.ShDepth !== 2'd2 || bus.ShErr !== 1'b1 || bus.PCout !== 20'h00400) begin
      fails++; $display("FAIL nest_overflow got=%0d/%b/%h exp=2/1/00400", bus.ShDepth, bus.ShErr, bus.PCout);
    end
    idle(); bus.RETI = 1; cyc();
    rd(4'd2, v); tests++;
    if (bus.PCout !== 20'h00200 || v !== 20'h00104 || bus.ShDepth !== 2'd1) begin
      fails++; $display("FAIL nest_pop1 got=%h/%h/%0d exp=00200/00104/1", bus.PCout, v, bus.ShDepth);
    end
    idle(); bus.RETI = 1; cyc();
    rd(4'd2, v); tests++;
    if (bus.PCout !== 20'h04000 || v !== 20'h00008 || bus.ShDepth !== 2'd0) begin
      fails++; $display("FAIL nest_pop2 got=%h/%h/%0d exp=04000/00008/0", bus.PCout, v, bus.ShDepth);
    end
    idle(); bus.RETI = 1; cyc();
    rd(4'd2, v); tests++;
    if (bus.PCout !== 20'h04000 || v !== 20'h00008 || bus.ShDepth !== 2'd0 || bus.ShErr !== 1'b1) begin
      fails++; $display("FAIL nest_underflow got=%h/%h/%0d/%b exp=04000/00008/0/1", bus.PCout, v, bus.ShDepth, bus.ShErr);
    end
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] v;
    wr(4'd4, 20'h12345);
    idle(); bus.INTACK = 1; bus.ISR = 20'h00800; cyc();
    #5;
    rst = 1'b1;
    #1;
    tests++;
    if (bus.PCout !== '0 || bus.SPout !== '0 || bus.ShDepth !== '0 || bus.ShErr !== 1'b0) begin
      fails++; $display("FAIL async_rst got=%h/%h/%0d/%b exp=0/0/0/0", bus.PCout, bus.SPout, bus.ShDepth, bus.ShErr);
    end
    rd(4'd4, v); tests++;
    if (v !== '0) begin fails++; $display("FAIL async_rst_R4 got=%h exp=0", v); end
    #2;
    rst = 1'b0;
    m_reset();
    idle(); bus.RETI = 1; cyc();
    tests++;
    if (bus.ShErr !== 1'b1 || bus.PCout !== '0 || bus.ShDepth !== '0) begin
      fails++; $display("FAIL rst_then_reti got=%b/%h/%0d exp=1/0/0", bus.ShErr, bus.PCout, bus.ShDepth);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] v;
    for (int n = 0; n < 150; n++) begin
      idle();
      bus.IdxF   = ($urandom_range(0, 5) == 0);
      bus.IF     = ($urandom_range(0, 5) == 0);
      bus.SPF    = ($urandom_range(0, 4) == 0);
      bus.INTACK = ($urandom_range(0, 4) == 0);
      bus.RETI   = ($urandom_range(0, 4) == 0);
      bus.Ex     = ($urandom_range(0, 3) == 0);
      bus.SRnew  = 4'($urandom_range(0, 15));
      bus.srcA   = 4'($urandom_range(0, 15));
      bus.dstA   = 4'($urandom_range(0, 15));
      bus.Size   = 2'($urandom_range(0, 3));
      bus.srcInc = ($urandom_range(0, 3) == 0);
      bus.dstInc = ($urandom_range(0, 3) == 0);
      bus.RW     = ($urandom_range(0, 1) == 0);
      bus.result = DW'($urandom);
      bus.ISR    = DW'($urandom);
      cyc();
      for (int i = 0; i < 16; i++) begin
        rd(4'(i), v);
        tests++;
        if (v !== m_r[i]) begin fails++; $display("FAIL rand%0d_R%0d got=%h exp=%h", n, i, v, m_r[i]); end
      end
      tests++;
      if (bus.SRcurrent !== {m_r[2][8], m_r[2][2:0]} || bus.GIE !== m_r[2][3] ||
          bus.ShDepth !== 2'(m_q.size()) || bus.ShErr !== m_err) begin
        fails++;
        $display("FAIL rand%0d_status got=%h/%b/%0d/%b exp=%h/%b/%0d/%b", n, bus.SRcurrent, bus.GIE,
                 bus.ShDepth, bus.ShErr, {m_r[2][8], m_r[2][2:0]}, m_r[2][3], m_q.size(), m_err);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    m_reset();
    idle();
    test_reset();
    #10;
    rst = 1'b0;
    test_rw();
    test_autoinc();
    test_priority();
    test_interrupt();
    test_nesting();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
